// File: rtl/alu_issue.sv
// alu_issue: decodes a MIPS instruction plus its register operands into an
// ALU operation, two operands and a write-back index, and buffers the result
// in a small valid/ready queue ahead of the execute stage. Unsupported
// encodings are still queued, marked illegal and counted.
module alu_issue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs_val_i,
  input  logic [31:0]      rt_val_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      d0_o,
  output logic [31:0]      d1_o,
  output logic [4:0]       alu_op_o,
  output logic [4:0]       dst_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_BGEZ = 5'd9;
  localparam logic [4:0] OP_BLEZ = 5'd10;
  localparam logic [4:0] OP_BGTZ = 5'd11;
  localparam logic [4:0] OP_LUI  = 5'd12;
  localparam logic [4:0] OP_SLTU = 5'd13;
  localparam logic [4:0] OP_SLT  = 5'd14;
  localparam logic [4:0] OP_SLLV = 5'd15;
  localparam logic [4:0] OP_SRLV = 5'd16;
  localparam logic [4:0] OP_SRAV = 5'd17;

  // Instruction fields. The rs index itself is not needed because the
  // register value arrives already read.
  logic [5:0]  opc;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        unused_rs_idx;

  assign opc           = instr_i[31:26];
  assign rt_idx        = instr_i[20:16];
  assign rd_idx        = instr_i[15:11];
  assign shamt         = instr_i[10:6];
  assign funct         = instr_i[5:0];
  assign imm           = instr_i[15:0];
  assign sext          = {{16{imm[15]}}, imm};
  assign zext          = {16'h0000, imm};
  assign unused_rs_idx = ^instr_i[25:21];

  logic [4:0]  dec_op;
  logic [31:0] dec_d0;
  logic [31:0] dec_d1;
  logic [4:0]  dec_dst;
  logic        dec_ill;

  // Combinational decode of the incoming instruction; illegal encodings
  // collapse to an all-zero entry with only the illegal flag set.
  always_comb begin
    dec_op  = OP_ADD;
    dec_d0  = '0;
    dec_d1  = '0;
    dec_dst = '0;
    dec_ill = 1'b0;
    case (opc)
      6'h00: begin
        dec_dst = rd_idx;
        dec_d0  = rs_val_i;
        dec_d1  = rt_val_i;
        case (funct)
          6'h20, 6'h21: dec_op = OP_ADD;
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h26:        dec_op = OP_XOR;
          6'h27:        dec_op = OP_NOR;
          6'h2A:        dec_op = OP_SLT;
          6'h2B:        dec_op = OP_SLTU;
          6'h00: begin
            dec_op = OP_SLL;
            dec_d0 = {27'd0, shamt};
          end
          6'h02: begin
            dec_op = OP_SRL;
            dec_d0 = {27'd0, shamt};
          end
          6'h03: begin
            dec_op = OP_SRA;
            dec_d0 = {27'd0, shamt};
          end
          6'h04:        dec_op = OP_SLLV;
          6'h06:        dec_op = OP_SRLV;
          6'h07:        dec_op = OP_SRAV;
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin
        dec_op  = OP_ADD;
        dec_d0  = rs_val_i;
        dec_d1  = sext;
        dec_dst = rt_idx;
      end
      6'h0A: begin
        dec_op  = OP_SLT;
        dec_d0  = rs_val_i;
        dec_d1  = sext;
        dec_dst = rt_idx;
      end
      6'h0B: begin
        dec_op  = OP_SLTU;
        dec_d0  = rs_val_i;
        dec_d1  = sext;
        dec_dst = rt_idx;
      end
      6'h0C: begin
        dec_op  = OP_AND;
        dec_d0  = rs_val_i;
        dec_d1  = zext;
        dec_dst = rt_idx;
      end
      6'h0D: begin
        dec_op  = OP_OR;
        dec_d0  = rs_val_i;
        dec_d1  = zext;
        dec_dst = rt_idx;
      end
      6'h0E: begin
        dec_op  = OP_XOR;
        dec_d0  = rs_val_i;
        dec_d1  = zext;
        dec_dst = rt_idx;
      end
      6'h0F: begin
        dec_op  = OP_LUI;
        dec_d0  = rs_val_i;
        dec_d1  = zext;
        dec_dst = rt_idx;
      end
      6'h23: begin
        dec_op  = OP_ADD;
        dec_d0  = rs_val_i;
        dec_d1  = sext;
        dec_dst = rt_idx;
      end
      6'h2B: begin
        dec_op  = OP_ADD;
        dec_d0  = rs_val_i;
        dec_d1  = sext;
      end
      6'h04, 6'h05: begin
        dec_op = OP_SUB;
        dec_d0 = rs_val_i;
        dec_d1 = rt_val_i;
      end
      6'h06: begin
        dec_op = OP_BLEZ;
        dec_d0 = rs_val_i;
      end
      6'h07: begin
        dec_op = OP_BGTZ;
        dec_d0 = rs_val_i;
      end
      6'h01: begin
        dec_op = OP_BGEZ;
        dec_d0 = rs_val_i;
        if (rt_idx == 5'd1) begin
          dec_d1 = 32'd1;
        end else if (rt_idx != 5'd0) begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op  = OP_ADD;
      dec_d0  = '0;
      dec_d1  = '0;
      dec_dst = '0;
    end
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  // Handshake qualifiers come from registered state only; flush wins over
  // both push and pop.
  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  logic [31:0] d0_mem  [DEPTH];
  logic [31:0] d1_mem  [DEPTH];
  logic [4:0]  op_mem  [DEPTH];
  logic [4:0]  dst_mem [DEPTH];
  logic        ill_mem [DEPTH];

  // Queue storage: the decoded entry is written at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d0_mem[i]  <= '0;
        d1_mem[i]  <= '0;
        op_mem[i]  <= '0;
        dst_mem[i] <= '0;
        ill_mem[i] <= 1'b0;
      end
    end else if (push) begin
      d0_mem[wr_ptr]  <= dec_d0;
      d1_mem[wr_ptr]  <= dec_d1;
      op_mem[wr_ptr]  <= dec_op;
      dst_mem[wr_ptr] <= dec_dst;
      ill_mem[wr_ptr] <= dec_ill;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [CNT_W-1:0] ill_cnt;

  // Saturating count of accepted illegal instructions; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (push && dec_ill && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + 1'b1;
    end
  end

  assign d0_o          = d0_mem[rd_ptr];
  assign d1_o          = d1_mem[rd_ptr];
  assign alu_op_o      = op_mem[rd_ptr];
  assign dst_o         = dst_mem[rd_ptr];
  assign illegal_o     = ill_mem[rd_ptr];
  assign illegal_cnt_o = ill_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with hand-computed decode results feed a
// scoreboard queue; a negedge monitor compares the queue head whenever the
// DUT presents a valid entry.
module tb_alu_issue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  op;
    logic [4:0]  dst;
    logic        ill;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [31:0]      rs_val_i;
  logic [31:0]      rt_val_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      d0_o;
  logic [31:0]      d1_o;
  logic [4:0]       alu_op_o;
  logic [4:0]       dst_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  int checks;
  int errors;
  int push_count;

  vec_t             cur_exp;
  vec_t             sb[$];
  vec_t             vecs[$];
  vec_t             ill_vec;
  logic [CNT_W-1:0] ill_model;
  logic             exp_push;
  logic             exp_pop;
  vec_t             head;

  alu_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .instr_i       (instr_i),
    .rs_val_i      (rs_val_i),
    .rt_val_i      (rt_val_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .d0_o          (d0_o),
    .d1_o          (d1_o),
    .alu_op_o      (alu_op_o),
    .dst_o         (dst_o),
    .illegal_o     (illegal_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [31:0] instr, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [4:0] op,
                                 input logic [4:0] dst, input logic ill);
    vec_t v;
    v.instr = instr;
    v.rs    = rs;
    v.rt    = rt;
    v.d0    = d0;
    v.d1    = d1;
    v.op    = op;
    v.dst   = dst;
    v.ill   = ill;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInput(input vec_t v);
    in_valid_i = 1'b1;
    instr_i    = v.instr;
    rs_val_i   = v.rs;
    rt_val_i   = v.rt;
    cur_exp    = v;
  endtask

  task automatic idleInputs();
    in_valid_i = 1'b0;
    instr_i    = '0;
    rs_val_i   = '0;
    rt_val_i   = '0;
  endtask

  // Present one instruction and wait (bounded) until the model sees it accepted.
  task automatic applyStimulus(input vec_t v);
    int start;
    bit done;
    start = push_count;
    done  = 1'b0;
    driveInput(v);
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk);
      #1;
      if (push_count != start) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no acceptance, expected acceptance of 0x%08h", v.instr);
    end
  endtask

  task automatic drainQueue();
    out_ready_i = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: compares the head entry and handshakes every cycle,
  // then advances the reference queue the way the next edge will.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      ill_model = '0;
    end else begin
      checkOutput("in_ready", 32'(in_ready_o), 32'(sb.size() != DEPTH));
      checkOutput("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
      checkOutput("illegal_cnt", 32'(illegal_cnt_o), 32'(ill_model));
      if (sb.size() != 0) begin
        head = sb[0];
        checkOutput("d0", d0_o, head.d0);
        checkOutput("d1", d1_o, head.d1);
        checkOutput("alu_op", 32'(alu_op_o), 32'(head.op));
        checkOutput("dst", 32'(dst_o), 32'(head.dst));
        checkOutput("illegal", 32'(illegal_o), 32'(head.ill));
      end
      exp_push = in_valid_i && (sb.size() != DEPTH) && !flush_i;
      exp_pop  = (sb.size() != 0) && out_ready_i && !flush_i;
      if (flush_i) begin
        sb.delete();
      end else begin
        if (exp_pop) void'(sb.pop_front());
        if (exp_push) begin
          sb.push_back(cur_exp);
          push_count++;
          if (cur_exp.ill && ill_model != '1) ill_model = ill_model + 1'b1;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    checks     = 0;
    errors     = 0;
    push_count = 0;
    ill_model  = '0;
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    out_ready_i = 1'b0;
    cur_exp    = '0;
    idleInputs();

    ill_vec = mkVec(32'hFC000000, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);

    vecs.push_back(mkVec(32'h2128FFFC, 32'd10, 32'h0, 32'd10, 32'hFFFFFFFC, 5'd0, 5'd8, 1'b0));
    vecs.push_back(mkVec(32'h000848C3, 32'h5, 32'h80000000, 32'd3, 32'h80000000, 5'd8, 5'd9, 1'b0));
    vecs.push_back(mkVec(32'h04210010, 32'd5, 32'h7, 32'd5, 32'd1, 5'd9, 5'd0, 1'b0));
    vecs.push_back(mkVec(32'h356A8001, 32'h12345678, 32'h0, 32'h12345678, 32'h00008001, 5'd3, 5'd10, 1'b0));
    vecs.push_back(mkVec(32'h012A4022, 32'd100, 32'd30, 32'd100, 32'd30, 5'd1, 5'd8, 1'b0));
    vecs.push_back(mkVec(32'h04200010, 32'hFFFFFFF0, 32'h3, 32'hFFFFFFF0, 32'd0, 5'd9, 5'd0, 1'b0));
    vecs.push_back(mkVec(32'h04220010, 32'hAAAA5555, 32'h3, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1));
    vecs.push_back(mkVec(32'hAD280004, 32'h00001000, 32'hDEAD, 32'h00001000, 32'd4, 5'd0, 5'd0, 1'b0));
    vecs.push_back(mkVec(32'h01494006, 32'd4, 32'hF0F0F0F0, 32'd4, 32'hF0F0F0F0, 5'd16, 5'd8, 1'b0));
    vecs.push_back(mkVec(32'h19200003, 32'h80000001, 32'h9, 32'h80000001, 32'd0, 5'd10, 5'd0, 1'b0));
    vecs.push_back(mkVec(32'h3C081234, 32'h77, 32'h0, 32'h77, 32'h00001234, 5'd12, 5'd8, 1'b0));

    // Reset state, checked while reset is held.
    #2;
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("rst_illegal_cnt", 32'(illegal_cnt_o), 32'd0);
    checkOutput("rst_d0", d0_o, 32'd0);
    checkOutput("rst_d1", d1_o, 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op_o), 32'd0);
    checkOutput("rst_dst", 32'(dst_o), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed decode vectors at full throughput.
    $display("[TB] decode vectors");
    out_ready_i = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i]);
    idleInputs();
    drainQueue();

    // Backpressure: third push stalls until the first pop.
    $display("[TB] backpressure");
    out_ready_i = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    driveInput(vecs[2]);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_in_ready_low", 32'(in_ready_o), 32'd0);
    checkOutput("bp_head_op", 32'(alu_op_o), 32'd0);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_after_pop", 32'(in_ready_o), 32'd1);
    applyStimulus(vecs[2]);
    idleInputs();
    drainQueue();

    // Flush together with a push while one entry is queued.
    $display("[TB] flush");
    out_ready_i = 1'b0;
    applyStimulus(vecs[3]);
    idleInputs();
    driveInput(vecs[4]);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    idleInputs();
    checkOutput("flush_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("flush_still_empty", 32'(out_valid_o), 32'd0);
    checkOutput("flush_keeps_cnt", 32'(illegal_cnt_o), 32'd1);

    // Asynchronous reset mid-stream with two entries queued.
    $display("[TB] async reset");
    applyStimulus(ill_vec);
    applyStimulus(vecs[5]);
    idleInputs();
    checkOutput("pre_rst_cnt", 32'(illegal_cnt_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("arst_illegal_cnt", 32'(illegal_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Illegal-instruction counter saturation.
    $display("[TB] illegal saturation");
    out_ready_i = 1'b1;
    for (int n = 0; n < 70000; n++) applyStimulus(ill_vec);
    idleInputs();
    drainQueue();
    checkOutput("sat_illegal_cnt", 32'(illegal_cnt_o), 32'h0000FFFF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
